// File: rtl/booth_seq_div.sv
// Sequential signed divider: radix-2 restoring division on magnitudes, one quotient
// bit per clock, signs applied in a final fix-up cycle. Truncating semantics.
module booth_seq_div #(
    parameter int width = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [2*width-1:0] dividend,
    input  logic [width-1:0]   divisor,
    output logic               busy,
    output logic               done,
    output logic [width-1:0]   quotient,
    output logic [width-1:0]   remainder,
    output logic               ovf,
    output logic               dvz
);

    localparam int DW = 2 * width;
    localparam int CW = $clog2(DW + 1);
    localparam logic [DW-1:0] QPOS_MAX = DW'(2 ** (width - 1) - 1);
    localparam logic [DW-1:0] QNEG_MAX = DW'(2 ** (width - 1));

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t state, state_nxt;

    // acc starts as the dividend magnitude and shifts quotient bits in from the LSB
    logic [DW-1:0]    acc;
    logic [width:0]   prem;
    logic [width-1:0] dmag;
    logic [CW-1:0]    cnt;
    logic             sign_q;
    logic             sign_r;
    logic             zdiv;

    logic [DW-1:0]    dvd_mag;
    logic [width-1:0] dsr_mag;
    logic [width:0]   prem_sh;
    logic [width:0]   trial;
    logic             take;
    logic             ovf_c;
    logic [width-1:0] q_sgn;
    logic [width-1:0] r_sgn;

    always_comb begin
        dvd_mag = dividend[DW-1] ? (~dividend + 1'b1) : dividend;
        dsr_mag = divisor[width-1] ? (~divisor + 1'b1) : divisor;
        prem_sh = {prem[width-1:0], acc[DW-1]};
        trial   = prem_sh - {1'b0, dmag};
        take    = (prem_sh >= {1'b0, dmag});
    end

    // Sign fix-up; the remainder magnitude is always below |divisor| so W bits suffice
    always_comb begin
        ovf_c = sign_q ? (acc > QNEG_MAX) : (acc > QPOS_MAX);
        q_sgn = sign_q ? (~acc[width-1:0] + 1'b1) : acc[width-1:0];
        r_sgn = sign_r ? (~prem[width-1:0] + 1'b1) : prem[width-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CALC;
            CALC:    if (cnt == CW'(1)) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            prem      <= '0;
            dmag      <= '0;
            cnt       <= '0;
            sign_q    <= 1'b0;
            sign_r    <= 1'b0;
            zdiv      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            ovf       <= 1'b0;
            dvz       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        acc    <= dvd_mag;
                        prem   <= '0;
                        dmag   <= dsr_mag;
                        cnt    <= CW'(DW);
                        sign_q <= dividend[DW-1] ^ divisor[width-1];
                        sign_r <= dividend[DW-1];
                        zdiv   <= (divisor == '0);
                        busy   <= 1'b1;
                    end
                end
                CALC: begin
                    acc  <= {acc[DW-2:0], take};
                    prem <= take ? trial : prem_sh;
                    cnt  <= cnt - 1'b1;
                end
                FIX: begin
                    done <= 1'b1;
                    busy <= 1'b0;
                    if (zdiv) begin
                        dvz       <= 1'b1;
                        ovf       <= 1'b0;
                        quotient  <= '0;
                        remainder <= '0;
                    end else if (ovf_c) begin
                        dvz       <= 1'b0;
                        ovf       <= 1'b1;
                        quotient  <= '0;
                        remainder <= '0;
                    end else begin
                        dvz       <= 1'b0;
                        ovf       <= 1'b0;
                        quotient  <= q_sgn;
                        remainder <= r_sgn;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_seq_div.sv
// Directed bench for booth_seq_div: product inversion sweep, sign cases, boundaries,
// divide by zero, handshake and asynchronous reset abort.
module tb_booth_seq_div;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [11:0] dividend = '0;
    logic [5:0]  divisor = '0;
    logic        busy, done, ovf, dvz;
    logic [5:0]  quotient, remainder;

    int n_chk = 0;
    int n_pass = 0;

    booth_seq_div #(.width(6)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
        .ovf(ovf), .dvz(dvz)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // Launch one op and return the cycle count from accept edge to done (-1 on timeout)
    task automatic op(input int a, input int b, output int lat);
        @(negedge clk);
        dividend = 12'(a);
        divisor  = 6'(b);
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic chk_op(input string tag, input int a, input int b, input int eq,
                          input int er, input int eovf, input int edvz);
        int lat;
        op(a, b, lat);
        chk({tag, " lat"}, lat, 13);
        chk({tag, " q"}, $signed(quotient), eq);
        chk({tag, " r"}, $signed(remainder), er);
        chk({tag, " ovf"}, int'(ovf), eovf);
        chk({tag, " dvz"}, int'(dvz), edvz);
    endtask

    initial begin
        int nd, first, d1, d2;

        #23;
        chk("rst busy", int'(busy), 0);
        chk("rst done", int'(done), 0);
        chk("rst q", int'(quotient), 0);
        chk("rst r", int'(remainder), 0);
        chk("rst ovf", int'(ovf), 0);
        chk("rst dvz", int'(dvz), 0);
        @(negedge clk) rst_n = 1'b1;

        for (int i = -31; i <= 31; i++)
            for (int j = -32; j <= 31; j++)
                if (j != 0) chk_op("sweep", i * j, j, i, 0, 0, 0);

        chk_op("43/5", 43, 5, 8, 3, 0, 0);
        chk_op("-43/5", -43, 5, -8, -3, 0, 0);
        chk_op("43/-5", 43, -5, -8, 3, 0, 0);
        chk_op("-43/-5", -43, -5, 8, -3, 0, 0);

        chk_op("1024/-32", 1024, -32, -32, 0, 0, 0);
        chk_op("-2048/-32", -2048, -32, 0, 0, 1, 0);
        chk_op("992/31", 992, 31, 0, 0, 1, 0);
        chk_op("961/31", 961, 31, 31, 0, 0, 0);
        chk_op("100/0", 100, 0, 0, 0, 0, 1);

        // start pulses and operand changes while busy must be ignored
        @(negedge clk);
        dividend = 12'(43);
        divisor  = 6'(5);
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        nd = 0;
        first = -1;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk);
            #1;
            if (done) begin
                nd++;
                if (first < 0) first = c;
            end
            if (c == 2) begin
                start = 1'b1;
                dividend = 12'(100);
            end
            if (c == 3) start = 1'b0;
            if (c == 5) start = 1'b1;
            if (c == 6) start = 1'b0;
        end
        chk("ign ndone", nd, 1);
        chk("ign lat", first, 13);
        chk("ign q", $signed(quotient), 8);
        chk("ign r", $signed(remainder), 3);

        // start held high: second op is accepted on the done-cycle edge
        @(negedge clk);
        dividend = 12'(43);
        divisor  = 6'(5);
        start    = 1'b1;
        @(posedge clk);
        #1 dividend = 12'(-43);
        d1 = -1;
        d2 = -1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (c == 14) begin
                chk("b2b busy", int'(busy), 1);
                start = 1'b0;
            end
            if (done) begin
                if (d1 < 0) begin
                    d1 = c;
                    chk("b2b q1", $signed(quotient), 8);
                    chk("b2b r1", $signed(remainder), 3);
                end else if (d2 < 0) begin
                    d2 = c;
                    chk("b2b q2", $signed(quotient), -8);
                    chk("b2b r2", $signed(remainder), -3);
                end
            end
        end
        chk("b2b d1", d1, 13);
        chk("b2b d2", d2, 27);

        // asynchronous reset in the middle of CALC aborts the op
        chk_op("pre", 43, 5, 8, 3, 0, 0);
        @(negedge clk);
        dividend = 12'(100);
        divisor  = 6'(7);
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("abort busy", int'(busy), 0);
        chk("abort done", int'(done), 0);
        chk("abort q", int'(quotient), 0);
        chk("abort r", int'(remainder), 0);
        chk("abort ovf", int'(ovf), 0);
        chk("abort dvz", int'(dvz), 0);
        nd = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (done) nd++;
        end
        chk("abort ndone", nd, 0);
        @(negedge clk) rst_n = 1'b1;
        chk_op("6/2", 6, 2, 3, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
